// File: rtl/led_scan_ctrl.sv
`timescale 1ns/1ps
// Row-multiplexed 16x16 LED matrix scanner reading a 256-word frame over RAM port B.
// Optional gamma mapping of pixel brightness when LED_SCAN_GAMMA_EN is defined.
module led_scan_ctrl #(
  parameter logic [15:0] BASE_ADDR   = 16'hC000,
  parameter int unsigned RD_LAT      = 2,
  parameter int unsigned STEP_CYCLES = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  output logic [15:0] address_b,
  output logic        wren_b,
  output logic [15:0] data_b,
  input  logic [15:0] q_b,
  output logic [3:0]  row_sel,
  output logic        row_en,
  output logic [15:0] col_on,
  output logic        frame_start,
  output logic        busy
);

  localparam int unsigned SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [4:0]    K_LAST = 5'(15 + RD_LAT);
  localparam logic [4:0]    K_LAT  = 5'(RD_LAT);
  localparam logic [SW-1:0] S_LAST = SW'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SHOW, S_NEXT} state_t;

  state_t            r_state, w_state_nxt;
  logic [4:0]        r_k, w_k_nxt;
  logic [3:0]        r_p, w_p_nxt;
  logic [SW-1:0]     r_s, w_s_nxt;
  logic [3:0]        r_row, w_row_nxt;
  logic [15:0][3:0]  r_bright, w_bright_nxt;
  logic [15:0]       w_addr_nxt;
  logic [15:0]       w_col_nxt;
  logic              w_fs_nxt;
  logic              w_row_en_nxt;
  logic              w_busy_nxt;
  logic              w_unused;

  // Only the low nibble of each word carries brightness.
  assign w_unused = ^q_b[15:4];

  function automatic logic [3:0] map_pix(input logic [3:0] v);
`ifdef LED_SCAN_GAMMA_EN
    case (v)
      4'd0:    return 4'd0;
      4'd1:    return 4'd0;
      4'd2:    return 4'd0;
      4'd3:    return 4'd1;
      4'd4:    return 4'd1;
      4'd5:    return 4'd1;
      4'd6:    return 4'd2;
      4'd7:    return 4'd2;
      4'd8:    return 4'd3;
      4'd9:    return 4'd4;
      4'd10:   return 4'd5;
      4'd11:   return 4'd6;
      4'd12:   return 4'd8;
      4'd13:   return 4'd10;
      4'd14:   return 4'd12;
      default: return 4'd15;
    endcase
`else
    return v;
`endif
  endfunction

  // Next-state and next-output logic; outputs are registered from these values.
  always_comb begin
    w_state_nxt  = r_state;
    w_k_nxt      = r_k;
    w_p_nxt      = r_p;
    w_s_nxt      = r_s;
    w_row_nxt    = r_row;
    w_bright_nxt = r_bright;
    w_fs_nxt     = 1'b0;
    w_addr_nxt   = BASE_ADDR;
    w_col_nxt    = '0;

    case (r_state)
      S_IDLE: begin
        if (enable) begin
          w_state_nxt = S_FETCH;
          w_k_nxt     = '0;
          w_row_nxt   = '0;
          w_fs_nxt    = 1'b1;
        end
      end
      S_FETCH: begin
        // Word for column k arrives RD_LAT cycles after its address.
        if (r_k >= K_LAT) begin
          w_bright_nxt[4'(r_k - K_LAT)] = map_pix(q_b[3:0]);
        end
        if (r_k == K_LAST) begin
          w_state_nxt = S_SHOW;
          w_k_nxt     = '0;
          w_p_nxt     = '0;
          w_s_nxt     = '0;
        end else begin
          w_k_nxt = r_k + 5'd1;
        end
      end
      S_SHOW: begin
        if (r_s == S_LAST) begin
          w_s_nxt = '0;
          if (r_p == 4'd14) begin
            w_state_nxt = S_NEXT;
            w_p_nxt     = '0;
          end else begin
            w_p_nxt = r_p + 4'd1;
          end
        end else begin
          w_s_nxt = r_s + SW'(1);
        end
      end
      S_NEXT: begin
        w_k_nxt = '0;
        if (enable) begin
          w_state_nxt = S_FETCH;
          w_row_nxt   = r_row + 4'd1;
          w_fs_nxt    = (r_row == 4'd15);
        end else begin
          w_state_nxt = S_IDLE;
          w_row_nxt   = '0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_row_en_nxt = (w_state_nxt == S_SHOW);
    w_busy_nxt   = (w_state_nxt != S_IDLE);

    // Address holds the last column during the read-latency overhang.
    if (w_state_nxt == S_FETCH) begin
      w_addr_nxt = BASE_ADDR + {8'h00, w_row_nxt,
                                (w_k_nxt > 5'd15) ? 4'hF : w_k_nxt[3:0]};
    end

    if (w_state_nxt == S_SHOW) begin
      for (int c = 0; c < 16; c++) begin
        w_col_nxt[c] = (w_bright_nxt[c] > w_p_nxt);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_k         <= '0;
      r_p         <= '0;
      r_s         <= '0;
      r_row       <= '0;
      r_bright    <= '0;
      address_b   <= BASE_ADDR;
      col_on      <= '0;
      row_en      <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_k         <= w_k_nxt;
      r_p         <= w_p_nxt;
      r_s         <= w_s_nxt;
      r_row       <= w_row_nxt;
      r_bright    <= w_bright_nxt;
      address_b   <= w_addr_nxt;
      col_on      <= w_col_nxt;
      row_en      <= w_row_en_nxt;
      frame_start <= w_fs_nxt;
      busy        <= w_busy_nxt;
    end
  end

  assign row_sel = r_row;
  assign wren_b  = 1'b0;
  assign data_b  = 16'h0000;

endmodule
